fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised successor to the single-entry fetch stage.
- Decouples instruction memory from decode with a DEPTH-entry prefetch FIFO of {pc, instruction} pairs.
- Issues sequential reads on a read/resp handshake while space remains, and presents the FIFO head to decode under a stall signal.
- On a branch/jump redirect: flushes the FIFO, discards any in-flight response, and restarts fetch at the target.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- XLEN, 32, width of PC and instruction words.
- RESET_PC, 32'h00000060, fetch PC loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- mem_read  out  1  instruction-memory read request.
- mem_address  out  XLEN  read address; equals fetch_pc.
- mem_rdata  in  XLEN  returned instruction word.
- mem_resp  in  1  read complete; mem_rdata valid this cycle.
- redirect  in  1  taken branch/jump from execute.
- redirect_pc  in  XLEN  target of the redirect.
- stall  in  1  decode cannot accept this cycle.
- valid  out  1  head entry valid.
- pc  out  XLEN  PC of head entry.
- instruction  out  XLEN  instruction of head entry.
- count  out  $clog2(DEPTH)+1  occupancy, for debug/perf.

Behaviour:
- Reset (async):
  - fetch_pc=RESET_PC; FIFO empty (count=0, valid=0, pc=0, instruction=0).
  - State=IDLE; mem_read=0.
- Handshakes:
  - Consume happens when valid && !stall; head pops at the next edge.
  - Push happens on mem_resp in state REQ and writes {fetch_pc, mem_rdata}; fetch_pc += 4 (mod 2^XLEN, wraps silently).
- Latency: a response at cycle t gives valid=1 at t+1. There is no bypass path.
- States (one request outstanding at most):
  - IDLE: mem_read=0. Go to REQ when space exists, i.e. count < DEPTH, or count==DEPTH with a pop this cycle.
  - REQ: mem_read=1; mem_address stable until mem_resp.
    - On mem_resp: push. Stay in REQ if space remains after this cycle's push/pop; otherwise go to IDLE.
  - DROP: mem_read stays 1 because the memory protocol must complete.
    - On mem_resp: discard the data and go to REQ at the new fetch_pc.
- Full: never enter REQ while count==DEPTH and there is no pop. Push and pop in the same cycle on a full FIFO is legal; count stays DEPTH.
- Empty: valid=0; stall is ignored; pop is suppressed.
- Redirect (highest priority, takes effect at the next edge):
  - FIFO flushed (count=0; valid=0 the next cycle); fetch_pc=redirect_pc.
  - Any push or pop in the same cycle is cancelled.
  - State transitions on redirect:
    - REQ without mem_resp the same cycle: go to DROP.
    - REQ with mem_resp the same cycle: data discarded; go to REQ at redirect_pc.
    - IDLE: go to REQ.
    - DROP: stay in DROP with the updated fetch_pc.
- Consecutive redirects: the last one wins.
- Reset asserted mid-request: the state machine returns to IDLE immediately, and the memory side is reset by the same signal.
- Pointers: log2(DEPTH) bits, wrap naturally. Occupancy is count, so full and empty are unambiguous.

Decomposition:
- rv32i_types additions:
  - typedef fetch_entry_t {rv32i_word pc; rv32i_word instr;}.
  - enum fetch_state_t {FQ_IDLE, FQ_REQ, FQ_DROP}.
- Sub-module fetch_fifo:
  - Parameters DEPTH and the entry type.
  - Ports: push, pop, flush, din, dout, count.
  - Flush has priority over push and pop.
- fetch_queue holds fetch_pc, the state machine, and the memory interface.

Test Plan:
- Reset release, memory returns resp every cycle, stall=0 → addresses 0x60, 0x64, 0x68, ... are issued. First valid comes one cycle after the first resp, with pc=0x60 and the matching instruction. Entries stay in order.
- stall=1 continuously, DEPTH=4 → exactly 4 responses are accepted, count=4, mem_read=0, head stays pc=0x60. Release stall → one pop per cycle and fetch resumes at 0x70.
- Redirect to 0x200 while a read is outstanding, with resp 3 cycles later → that response is discarded (no valid). The next request address is 0x200, and the first valid entry has pc=0x200.
- Redirect in the same cycle as mem_resp, with valid && !stall → no push and no pop. FIFO is empty the next cycle, and the next mem_address is redirect_pc.
- Full FIFO, push and pop in the same cycle → count stays 4, order is preserved, and no entry is lost or duplicated.
- Reset asserted mid-REQ with 2 entries queued → immediately valid=0, count=0, mem_read=0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types for the prefetch queue: entry layout and fetch state encoding.
package fetch_queue_pkg;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FQ_IDLE,
    FQ_REQ,
    FQ_DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry FIFO of fetch entries; flush wins over push and pop.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 din,
  output entry_t                 dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, do_push, do_pop;
  entry_t        mem_q [DEPTH];

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: sequential reads into a FIFO, flushed on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h00000060
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_read,
  output logic [XLEN-1:0]        mem_address,
  input  logic [XLEN-1:0]        mem_rdata,
  input  logic                   mem_resp,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   stall,
  output logic                   valid,
  output logic [XLEN-1:0]        pc,
  output logic [XLEN-1:0]        instruction,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            mem_read_q, mem_read_d;

  logic            push, pop;
  entry_t          din, dout;
  logic [CW-1:0]   fifo_cnt, cnt_after;
  logic            space_now, room_after;

  assign valid = (fifo_cnt != '0);
  assign pop   = valid && !stall && !redirect;
  assign push  = (state_q == FQ_REQ) && mem_resp && !redirect;
  assign din   = '{pc: fetch_pc_q, instr: mem_rdata};

  assign cnt_after  = fifo_cnt + CW'(push) - CW'(pop);
  assign space_now  = (fifo_cnt < CW'(DEPTH)) || pop;
  assign room_after = (cnt_after < CW'(DEPTH));

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .dout  (dout),
    .count (fifo_cnt)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      case (state_q)
        FQ_IDLE: state_d = FQ_REQ;
        // An unanswered read must still complete; its data is thrown away.
        FQ_REQ:  state_d = mem_resp ? FQ_REQ : FQ_DROP;
        FQ_DROP: state_d = FQ_DROP;
        default: state_d = FQ_IDLE;
      endcase
    end else begin
      case (state_q)
        FQ_IDLE: if (space_now) state_d = FQ_REQ;
        FQ_REQ: begin
          if (mem_resp) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            state_d    = room_after ? FQ_REQ : FQ_IDLE;
          end
        end
        FQ_DROP: if (mem_resp) state_d = FQ_REQ;
        default: state_d = FQ_IDLE;
      endcase
    end
    mem_read_d = (state_d != FQ_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FQ_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_read_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_read_q <= mem_read_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_address = fetch_pc_q;
  assign pc          = valid ? dout.pc : '0;
  assign instruction = valid ? dout.instr : '0;
  assign count       = fifo_cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue with a zero-latency memory model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];

  typedef struct {
    logic        st;
    logic        mr;
    logic [31:0] addr;
    logic        vld;
    logic [2:0]  cnt;
    logic [31:0] hpc;
  } vec_t;

  vec_t tbl[16];

  fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .valid       (valid),
    .pc          (pc),
    .instruction (instruction),
    .count       (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  function automatic vec_t v(input logic st, input logic mr, input logic [31:0] addr,
                             input logic vld, input logic [2:0] cnt, input logic [31:0] hpc);
    vec_t r;
    r.st = st; r.mr = mr; r.addr = addr; r.vld = vld; r.cnt = cnt; r.hpc = hpc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs (called at a negedge), update the scoreboard, advance.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic ren, input logic acc);
    logic [63:0] e;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    mem_resp    = mem_read && ren;
    mem_rdata   = acc ? instr_of(mem_address) : 32'hDEAD_BEEF;
    if (valid && !st && !rd) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", pc, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", pc, e[63:32]);
        chk("pop_instr", instruction, e[31:0]);
      end
    end
    if (rd) sb.delete();
    else if (mem_resp && acc) sb.push_back({mem_address, instr_of(mem_address)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_resp    = 1'b0;
    mem_rdata   = '0;
    #3;
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instruction, 0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    // Stall-until-full then release, and a second fill from the steady state.
    tbl[0]  = v(1, 0, 32'h00, 0, 0, 32'h00);
    tbl[1]  = v(1, 1, 32'h60, 0, 0, 32'h00);
    tbl[2]  = v(1, 1, 32'h64, 1, 1, 32'h60);
    tbl[3]  = v(1, 1, 32'h68, 1, 2, 32'h60);
    tbl[4]  = v(1, 1, 32'h6C, 1, 3, 32'h60);
    tbl[5]  = v(1, 0, 32'h00, 1, 4, 32'h60);
    tbl[6]  = v(0, 0, 32'h00, 1, 4, 32'h60);
    tbl[7]  = v(0, 1, 32'h70, 1, 3, 32'h64);
    tbl[8]  = v(0, 1, 32'h74, 1, 3, 32'h68);
    tbl[9]  = v(0, 1, 32'h78, 1, 3, 32'h6C);
    tbl[10] = v(0, 1, 32'h7C, 1, 3, 32'h70);
    tbl[11] = v(0, 1, 32'h80, 1, 3, 32'h74);
    tbl[12] = v(1, 1, 32'h84, 1, 3, 32'h78);
    tbl[13] = v(1, 0, 32'h00, 1, 4, 32'h78);
    tbl[14] = v(0, 0, 32'h00, 1, 4, 32'h78);
    tbl[15] = v(0, 1, 32'h88, 1, 3, 32'h7C);

    // Streaming with no stall.
    do_reset();
    chk("stream_c0_read", 32'(mem_read), 0);
    cycle(0, 0, 0, 1, 1);
    for (int k = 1; k <= 12; k++) begin
      chk("stream_read", 32'(mem_read), 1);
      chk("stream_addr", mem_address, 32'h60 + 32'(4 * (k - 1)));
      if (k == 1) chk("stream_first_valid", 32'(valid), 0);
      else begin
        chk("stream_valid", 32'(valid), 1);
        chk("stream_count", 32'(count), 1);
      end
      if (k == 2) chk("stream_first_pc", pc, 32'h60);
      cycle(0, 0, 0, 1, 1);
    end

    // Full FIFO under stall, then release.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("tbl_read", 32'(mem_read), 32'(tbl[i].mr));
      if (tbl[i].mr) chk("tbl_addr", mem_address, tbl[i].addr);
      chk("tbl_valid", 32'(valid), 32'(tbl[i].vld));
      chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
      chk("tbl_head_pc", pc, tbl[i].hpc);
      cycle(tbl[i].st, 0, 0, 1, 1);
    end

    // Redirect with a read outstanding; its late response must be dropped.
    do_reset();
    cycle(0, 0, 0, 0, 1);
    chk("drop_req_addr", mem_address, 32'h60);
    cycle(0, 1, 32'h200, 0, 1);
    chk("drop_read_held", 32'(mem_read), 1);
    chk("drop_valid_c2", 32'(valid), 0);
    cycle(0, 0, 0, 0, 1);
    chk("drop_valid_c3", 32'(valid), 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 0);
    chk("drop_valid_after", 32'(valid), 0);
    chk("drop_next_read", 32'(mem_read), 1);
    chk("drop_next_addr", mem_address, 32'h200);
    cycle(0, 0, 0, 1, 1);
    chk("drop_first_valid", 32'(valid), 1);
    chk("drop_first_pc", pc, 32'h200);
    cycle(0, 0, 0, 0, 1);

    // Redirect coinciding with resp and a pop, back-to-back redirects, PC wrap.
    do_reset();
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    chk("same_pre_valid", 32'(valid), 1);
    chk("same_pre_count", 32'(count), 1);
    cycle(0, 1, 32'h300, 1, 0);
    chk("same_valid", 32'(valid), 0);
    chk("same_count", 32'(count), 0);
    chk("same_read", 32'(mem_read), 1);
    chk("same_addr", mem_address, 32'h300);
    cycle(0, 1, 32'h340, 1, 0);
    chk("back2back_valid", 32'(valid), 0);
    chk("back2back_addr", mem_address, 32'h340);
    cycle(0, 0, 0, 1, 1);
    chk("back2back_pc", pc, 32'h340);
    chk("back2back_next", mem_address, 32'h344);
    cycle(0, 1, 32'hFFFF_FFFC, 1, 0);
    chk("wrap_addr", mem_address, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1, 1);
    chk("wrap_next_addr", mem_address, 32'h0000_0000);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1, 1);

    // Reset asserted mid-request with two entries queued.
    do_reset();
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    chk("midrst_pre_count", 32'(count), 2);
    chk("midrst_pre_read", 32'(mem_read), 1);
    reset = 1'b1;
    #2;
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_read", 32'(mem_read), 0);
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    sb.delete();
    chk("midrst_c0_read", 32'(mem_read), 0);
    cycle(0, 0, 0, 1, 1);
    chk("midrst_c1_read", 32'(mem_read), 1);
    chk("midrst_c1_addr", mem_address, 32'h60);
    cycle(0, 0, 0, 1, 1);
    chk("midrst_c2_pc", pc, 32'h60);
    cycle(0, 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
